// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   INSTR_W / PC_W      : instruction and word-address widths
//   NOP_INSTR / PC_RESET: bubble encoding and reset PC
//   fetch_state_t       : fetch FSM states
package fetch_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 20'h00000;
  localparam logic [PC_W-1:0]    PC_RESET  = 16'h0000;

  typedef enum logic [1:0] {
    BUBBLE,
    RUN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating performance counters for the fetch stage.
// Ports:
//   clk           : clock, rising edge
//   reset         : synchronous active-low reset
//   count_fetch_i : one accepted instruction this cycle
//   count_stall_i : one stalled cycle this cycle
//   fetch_count_o : accepted-instruction count, saturates at all-ones
//   stall_count_o : stalled-cycle count, saturates at all-ones
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_fetch_i,
  input  logic        count_stall_i,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (count_fetch_i && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (count_stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign stall_count_o = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory address from pc_q and presents
// the returned word (1-cycle read latency) to the FetchDecode register, with stall
// (hold) and flush (branch redirect) handling.
// Ports:
//   clk, reset          : clock and synchronous active-low reset
//   stall               : 1 = freeze the presented instruction
//   flush               : 1 = redirect to branch_address (wins over stall)
//   branch_address      : redirect target word address
//   imem_addr           : instruction memory read address (= pc_q)
//   imem_rdata          : instruction memory data, one cycle after imem_addr
//   instruction_fetch   : presented instruction (NOP in bubbles)
//   pc_fetch            : PC of instruction_fetch
//   valid_fetch         : 1 = real instruction, 0 = bubble
//   fetch_count         : accepted-instruction counter
//   stall_count         : stalled-cycle counter
// Build option: define FETCH_PERF_CNT_EN to enable the counters; otherwise they read 0.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_address,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction_fetch,
  output logic [PC_W-1:0]    pc_fetch,
  output logic               valid_fetch,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic [INSTR_W-1:0] hold_q, hold_d;

  assign imem_addr = pc_q;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    inflight_pc_d     = inflight_pc_q;
    hold_d            = hold_q;
    instruction_fetch = NOP_INSTR;
    valid_fetch       = 1'b0;
    pc_fetch          = inflight_pc_q;

    unique case (state_q)
      BUBBLE: begin
        // The word addressed now returns next cycle, so track its PC as in flight.
        if (!stall) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 16'd1;
          state_d       = RUN;
        end
      end
      RUN: begin
        instruction_fetch = imem_rdata;
        valid_fetch       = 1'b1;
        if (stall) begin
          // Memory moves on to pc_q next cycle, so keep the shown word locally.
          hold_d  = imem_rdata;
          state_d = HOLD;
        end else begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 16'd1;
        end
      end
      HOLD: begin
        instruction_fetch = hold_q;
        valid_fetch       = 1'b1;
        if (!stall) begin
          inflight_pc_d = pc_q;
          pc_d          = pc_q + 16'd1;
          state_d       = RUN;
        end
      end
      default: state_d = BUBBLE;
    endcase

    // Redirect overrides everything; outputs this cycle still reflect state_q.
    if (flush) begin
      pc_d    = branch_address;
      hold_d  = NOP_INSTR;
      state_d = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BUBBLE;
      pc_q          <= PC_RESET;
      inflight_pc_q <= PC_RESET;
      hold_q        <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_q        <= hold_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf_counters (
    .clk           (clk),
    .reset         (reset),
    .count_fetch_i (valid_fetch & ~stall & ~flush),
    .count_stall_i (stall),
    .fetch_count_o (fetch_count),
    .stall_count_o (stall_count)
  );
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [15:0] branch_address;
  logic [15:0] imem_addr;
  logic [19:0] imem_rdata;
  logic [19:0] instruction_fetch;
  logic [15:0] pc_fetch;
  logic        valid_fetch;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_unit u_dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .branch_address    (branch_address),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .instruction_fetch (instruction_fetch),
    .pc_fetch          (pc_fetch),
    .valid_fetch       (valid_fetch),
    .fetch_count       (fetch_count),
    .stall_count       (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency ROM: imem[a] = 20'hA0000 | a
  always @(posedge clk) imem_rdata <= 20'hA0000 | {4'h0, imem_addr};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid instruction shown for a given PC
  task automatic expect_instr(input string tag, input logic [15:0] pc);
    check_eq({tag, " valid"}, 32'(valid_fetch), 32'd1);
    check_eq({tag, " pc"}, 32'(pc_fetch), 32'(pc));
    check_eq({tag, " instr"}, 32'(instruction_fetch), 32'(20'hA0000 | {4'h0, pc}));
  endtask

  task automatic expect_bubble(input string tag);
    check_eq({tag, " valid"}, 32'(valid_fetch), 32'd0);
    check_eq({tag, " instr"}, 32'(instruction_fetch), 32'h0);
  endtask

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    branch_address = 16'h0;
    tick();
    tick();

    // Reset state
    expect_bubble("rst");
    check_eq("rst pc_fetch", 32'(pc_fetch), 32'h0);
    check_eq("rst imem_addr", 32'(imem_addr), 32'h0);
    check_eq("rst fetch_count", fetch_count, 32'h0);
    check_eq("rst stall_count", stall_count, 32'h0);

    // Release: one bubble, then PC 0..5 streaming
    reset = 1'b1;
    expect_bubble("rel bubble");
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_instr($sformatf("stream%0d", i), 16'(i));
    end

    // Stall 3 cycles while PC 5 shown: A0005 for 4 cycles, then A0006
    stall = 1'b1;
    expect_instr("stall c1", 16'd5);
    tick();
    expect_instr("stall c2", 16'd5);
    check_eq("stall pc frozen", 32'(imem_addr), 32'd6);
    tick();
    expect_instr("stall c3", 16'd5);
    tick();
    stall = 1'b0;
    expect_instr("stall c4", 16'd5);
    for (int i = 6; i < 10; i++) begin
      tick();
      expect_instr($sformatf("post stall%0d", i), 16'(i));
    end

    // Flush at PC 9 to 0x0002
    flush          = 1'b1;
    branch_address = 16'h0002;
    expect_instr("flush cycle", 16'd9);
    tick();
    flush = 1'b0;
    expect_bubble("flush bubble");
    tick();
    expect_instr("flush tgt", 16'd2);
    tick();
    expect_instr("flush tgt+1", 16'd3);

    // Flush and stall together: flush wins
    flush          = 1'b1;
    stall          = 1'b1;
    branch_address = 16'h0010;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    expect_bubble("fs bubble");
    check_eq("fs imem_addr", 32'(imem_addr), 32'h10);
    tick();
    expect_instr("fs tgt", 16'h0010);

    // PC wrap
    flush          = 1'b1;
    branch_address = 16'hFFFF;
    tick();
    flush = 1'b0;
    expect_bubble("wrap bubble");
    tick();
    expect_instr("wrap ffff", 16'hFFFF);
    tick();
    expect_instr("wrap 0000", 16'h0000);

    // Reset mid-HOLD, with stall still high
    stall = 1'b1;
    tick();
    expect_instr("hold pre-rst", 16'h0000);
    reset = 1'b0;
    tick();
    expect_bubble("hold rst");
    check_eq("hold rst imem_addr", 32'(imem_addr), 32'h0);
    check_eq("hold rst fetch_count", fetch_count, 32'h0);
    check_eq("hold rst stall_count", stall_count, 32'h0);
    reset = 1'b1;
    stall = 1'b0;
    tick();
    expect_instr("restart", 16'h0000);

    // 10 accepted + 3 stalled cycles
    for (int i = 1; i <= 10; i++) begin
      tick();
    end
    expect_instr("cnt run", 16'd10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    expect_instr("cnt held", 16'd10);
`ifdef FETCH_PERF_CNT_EN
    check_eq("fetch_count", fetch_count, 32'd10);
    check_eq("stall_count", stall_count, 32'd3);
`else
    check_eq("fetch_count off", fetch_count, 32'd0);
    check_eq("stall_count off", stall_count, 32'd0);
`endif
    stall = 1'b0;
    tick();
    expect_instr("cnt resume", 16'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
